// File: rtl/pc_gen.sv
// Purpose: fetch-stage program counter with branch/jump/exception redirect selection.
// Latency: a redirect presented in cycle N appears on pc at N+1, with flush high during N+1.
// Backpressure: stall holds pc; a redirect arriving while stalled is latched and applied on release.
module pc_gen #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] dec_pc,
    input  logic [2:0]        br_op,
    input  logic [15:0]       br_offset,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    input  logic              jump,
    input  logic [25:0]       j_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic              flush,
    output logic              pend_valid
);

    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] INC4   = ADDR_W'(4);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_op_t;

    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] dpc4;
    logic [ADDR_W-1:0] boff;
    logic [ADDR_W-1:0] bt;
    logic [ADDR_W-1:0] jt;
    logic [ADDR_W-1:0] rtarget;
    logic              br_taken;
    logic              redirect;
    logic              exc_any;
    logic signed [31:0] rs_s;

    // Target arithmetic; all sums wrap modulo 2^ADDR_W.
    always_comb begin
        seq  = pc + INC4;
        dpc4 = dec_pc + INC4;
        boff = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
        bt   = dpc4 + boff;
        // Jump region comes from the delay-slot address, not the branch itself.
        jt   = {dpc4[ADDR_W-1:28], j_index, 2'b00};
    end

    // Branch condition evaluation; single-operand compares are signed against zero.
    always_comb begin
        rs_s     = $signed(rs_val);
        br_taken = 1'b0;
        case (br_op_t'(br_op))
            BR_BEQ:  br_taken = (rs_val == rt_val);
            BR_BNE:  br_taken = (rs_val != rt_val);
            BR_BLEZ: br_taken = (rs_s <= 32'sd0);
            BR_BGTZ: br_taken = (rs_s >  32'sd0);
            BR_BLTZ: br_taken = (rs_s <  32'sd0);
            BR_BGEZ: br_taken = (rs_s >= 32'sd0);
            BR_NONE, BR_RSVD: br_taken = 1'b0;
            default: br_taken = 1'b0;
        endcase
    end

    // Redirect source priority: exception > eret > jr > jump > taken branch.
    always_comb begin
        exc_any  = exc_req | eret;
        redirect = exc_req | eret | jr | jump | br_taken;
        rtarget  = '0;
        if (exc_req)       rtarget = EXC_PC;
        else if (eret)     rtarget = epc;
        else if (jr)       rtarget = jr_target;
        else if (jump)     rtarget = jt;
        else if (br_taken) rtarget = bt;
    end

    assign pc4 = seq;

    // PC register, pending-redirect latch and registered flush pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RST_PC;
            flush       <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (!stall) begin
            if (exc_any) begin
                // Exceptions and ERET always win, even over a latched redirect.
                pc         <= rtarget;
                pend_valid <= 1'b0;
                flush      <= 1'b1;
            end else if (pend_valid) begin
                // Decode is re-presenting the same instruction; its redirect is already latched.
                pc         <= pend_target;
                pend_valid <= 1'b0;
                flush      <= 1'b1;
            end else if (redirect) begin
                pc    <= rtarget;
                flush <= 1'b1;
            end else begin
                pc    <= seq;
                flush <= 1'b0;
            end
        end else begin
            flush <= 1'b0;
            if (exc_any) begin
                pend_target <= rtarget;
                pend_valid  <= 1'b1;
            end else if (redirect && !pend_valid) begin
                // Keep the first redirect seen during a stall; later ones are stale re-presentations.
                pend_target <= rtarget;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the MIPS fetch stage, replacing the purely combinational next-PC logic. It owns the PC register and handles sequential fetch, conditional branches (six compare modes), J/JAL, JR/JALR, exception entry and ERET. A redirect that arrives during a stall is latched and applied once the stall releases. It also emits a registered one-cycle flush pulse for the IF/ID register.

Parameters:
ADDR_W, 32, PC width; legal range 30..32; jump region bits are PC[ADDR_W-1:28].
RESET_PC, 32'h0000_3000, PC value loaded on reset (truncated to ADDR_W).
EXC_VEC, 32'h0000_4180, exception entry address (truncated to ADDR_W).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold PC (hazard/cache miss)
dec_pc  in  ADDR_W  PC of the instruction currently in decode
br_op  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none)
br_offset  in  16  branch immediate
rs_val  in  32  rs operand (signed compare)
rt_val  in  32  rt operand
jump  in  1  J/JAL in decode
j_index  in  26  jump instr_index
jr  in  1  JR/JALR in decode
jr_target  in  ADDR_W  register target
exc_req  in  1  exception request
eret  in  1  return from exception
epc  in  ADDR_W  ERET target
pc  out  ADDR_W  current fetch address
pc4  out  ADDR_W  pc + 4
flush  out  1  registered pulse: fetched instruction must be discarded
pend_valid  out  1  redirect latched, waiting on stall release

Behaviour:
- Reset: when rst_n=0 at posedge, pc<=RESET_PC, flush<=0, pend_valid<=0, pend_target<=0; reset overrides stall and every other input.
- Targets (combinational, all modulo 2^ADDR_W):
  - seq = pc+4
  - bt = dec_pc + 4 + (sign-extend(br_offset) << 2)
  - jt = {(dec_pc+4)[ADDR_W-1:28], j_index, 2'b00}
- Branch taken:
  - beq: rs==rt; bne: rs!=rt
  - blez: rs<=0; bgtz: rs>0; bltz: rs<0; bgez: rs>=0 (signed)
  - br_op 0 or 7: never taken
- Redirect priority: exc_req > eret > jr > jump > taken branch > none.
  - Call the selected target rtarget; redirect = any source active.
- Unstalled cycle (stall=0):
  - exc_req or eret: pc<=rtarget; pend cleared.
  - else if pend_valid: pc<=pend_target, pend_valid<=0. New jr/jump/branch inputs this cycle are ignored; they belong to the same, re-presented instruction.
  - else if redirect: pc<=rtarget.
  - else: pc<=seq.
  - flush<=1 when pc loaded from any non-seq source, else 0.
- Stalled cycle (stall=1):
  - pc holds; flush<=0.
  - exc_req or eret: pend_target<=rtarget, pend_valid<=1, overwriting any existing pending entry.
  - else if redirect and !pend_valid: latch rtarget, pend_valid<=1.
  - else if redirect and pend_valid: no change (first latched redirect kept).
- Latency: a redirect presented in cycle N (unstalled) appears on pc at N+1, with flush=1 during N+1.
- Exception asserted on the same cycle stall releases beats a pending redirect.
- Reset mid-stall with pending redirect: pending discarded, pc=RESET_PC.
- pc4 is combinational from pc.
- No alignment checks; misaligned jr_target/epc pass through unchanged.

Test Plan:
1. Reset then 3 free cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; flush=0 throughout.
2. dec_pc=0x3004, br_op=1, rs=rt=5, br_offset=0xFFFE, stall=0 -> next pc=0x3000, flush=1 for one cycle. With rs=5, rt=6 -> pc=0x300C (sequential), no flush.
3. Signed compares with rs=0x8000_0000:
   - bltz, bgtz, blez, bgez -> taken, not taken, taken, not taken.
   - bgtz with rs=0 -> not taken.
4. Jump, dec_pc=0x3FFF_FFFC, j_index=0x3FF_FFFF -> pc=0x4FFF_FFFC (region taken from dec_pc+4=0x4000_0000). Same cycle with jr=1, jr_target=0x1234 -> pc=0x1234.
5. stall=1 for 3 cycles, jump to 0x3400 in the first stalled cycle, then a bne taken to 0x5000:
   - pc held, pend_valid=1, pend_target stays 0x3400.
   - Release stall -> pc=0x3400, flush=1, pend_valid=0.
6. Exception cases:
   - Stalled with pending 0x3400, exc_req pulses -> pend_target becomes 0x4180; on release pc=0x4180.
   - Unstalled eret with epc=0x3010 and simultaneous jump -> pc=0x3010.
   - rst_n=0 during a pending stall -> pc=0x3000, pend_valid=0.
